// File: rtl/regbank_pkg.sv
// Shared constants and FSM state type for the register bank write arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regbank_pkg;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    // INIT clears the bank one register per cycle; RUN arbitrates requester writes.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regbank_arb_pick.sv
// Winner picker: first eligible requester found searching upward from ptr+1 (wrapping).
// Latency: combinational, zero cycles.
// Backpressure: none; an all-zero eligible vector yields an all-zero winner.
//
// Ports:
//   eligible  requests allowed to compete this cycle
//   ptr       index of the last winner; the search begins just above it
//   winner    one-hot winner, zero when nothing is eligible
module regbank_arb_pick #(
    parameter  int NUM_REQ = 3,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && eligible[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Register bank write arbiter: clears every register after reset, then grants one requester write per cycle.
// Latency: one cycle from sampled req to registered gnt/enable/load_data.
// Backpressure: losers keep req high and retry; last cycle's winner sits out one edge so others get a turn.
//
// Optional feature: macro REGBANK_ARB_ROUND_ROBIN_EN selects rotating priority;
// left undefined, the lowest-index eligible requester always wins.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   req          per-requester write request
//   req_addr     packed register index per requester
//   req_data     packed write data per requester
//   gnt          one-hot grant pulse (registered)
//   enable       one-hot register load enable to the bank (registered)
//   load_data    write data to the bank (registered, holds when idle)
//   init_done    high once the clear sequence has finished
module regbank_write_arbiter #(
    parameter  int NUM_REQ  = 3,
    parameter  int DATA_W   = regbank_pkg::DATA_W,
    parameter  int NUM_REGS = regbank_pkg::NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REGS-1:0]       enable,
    output logic [DATA_W-1:0]         load_data,
    output logic                      init_done
);

    import regbank_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   cnt_q,       cnt_d;
    logic [NUM_REQ-1:0]  gnt_q,       gnt_d;
    logic [NUM_REGS-1:0] enable_q,    enable_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                init_done_q, init_done_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  win_oh;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [PTR_W-1:0]    arb_ptr;

`ifdef REGBANK_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_idx;
    assign arb_ptr = ptr_q;
`else
    // Pointer parked on the top index makes the search start at requester 0,
    // which is plain lowest-index-wins priority.
    assign arb_ptr = PTR_W'(NUM_REQ - 1);
`endif

    // Last edge's winner is masked so a requester holding req high cannot
    // win back-to-back.
    assign eligible = req & ~gnt_q;

    regbank_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eligible (eligible),
        .ptr      (arb_ptr),
        .winner   (win_oh)
    );

    // One-hot winner to its address/data slices.
    always_comb begin
        win_addr = '0;
        win_data = '0;
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
        win_idx  = '0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
                win_idx  = PTR_W'(i);
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        enable_d    = '0;
        load_data_d = load_data_q;
        init_done_d = init_done_q;
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            INIT: begin
                // Requests are ignored entirely while the bank is cleared.
                enable_d    = NUM_REGS'(1) << cnt_q;
                load_data_d = '0;
                if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            RUN: begin
                init_done_d = 1'b1;
                if (|eligible) begin
                    gnt_d       = win_oh;
                    enable_d    = NUM_REGS'(1) << win_addr;
                    load_data_d = win_data;
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
                    ptr_d       = win_idx;
`endif
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            gnt_q       <= '0;
            enable_q    <= '0;
            load_data_q <= '0;
            init_done_q <= 1'b0;
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
            ptr_q       <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            enable_q    <= enable_d;
            load_data_q <= load_data_d;
            init_done_q <= init_done_d;
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign enable    = enable_q;
    assign load_data = load_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: reference model predicts every cycle's outputs into a queue,
// a monitor on the falling edge pops and compares.
// Stimulus: directed init/grant/collision/reset scenarios followed by randomized requesters.
module tb_regbank_write_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REGS-1:0]       enable;
    logic [DATA_W-1:0]         load_data;
    logic                      init_done;

    regbank_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .enable    (enable),
        .load_data (load_data),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REQ-1:0]  gnt;
        logic [NUM_REGS-1:0] en;
        logic [DATA_W-1:0]   ld;
        logic                done;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state, kept in terms of "edges since reset released".
    int               m_cyc  = 0;
    int               m_prev = -1;       // requester granted at previous edge, -1 none
    int               m_last = NUM_REQ-1; // last winner, rotating search starts above it
    logic [DATA_W-1:0] m_ld  = '0;
    int               m_gnt_now = -1;   // winner chosen at the most recent edge

    task automatic model_edge();
        exp_t e;
        e.gnt  = '0;
        e.en   = '0;
        e.done = 1'b0;
        m_gnt_now = -1;
        if (reset) begin
            m_cyc  = 0;
            m_prev = -1;
            m_last = NUM_REQ - 1;
            m_ld   = '0;
        end else begin
            m_cyc++;
            if (m_cyc <= NUM_REGS) begin
                // Clear sequence: edge n writes zero into register n-1.
                e.en = NUM_REGS'(1) << (m_cyc - 1);
                m_ld = '0;
            end else begin
                // Clear finished after NUM_REGS edges; done reported from the next edge on.
                e.done = 1'b1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    int i;
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
                    i = (m_last + 1 + k) % NUM_REQ;
`else
                    i = k;
`endif
                    if (m_gnt_now < 0 && req[i] && i != m_prev) m_gnt_now = i;
                end
                if (m_gnt_now >= 0) begin
                    e.gnt  = NUM_REQ'(1) << m_gnt_now;
                    e.en   = NUM_REGS'(1) << req_addr[m_gnt_now*ADDR_W +: ADDR_W];
                    m_ld   = req_data[m_gnt_now*DATA_W +: DATA_W];
                    m_last = m_gnt_now;
                end
                m_prev = m_gnt_now;
            end
        end
        e.ld = m_ld;
        exp_q.push_back(e);
    endtask

    // One clock: model sees the same inputs the DUT sampled, then inputs may change.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_txn(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Monitor: every falling edge with a pending prediction is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (gnt !== e.gnt) begin
                    failures++;
                    $display("FAIL gnt t=%0t got=%b exp=%b", $time, gnt, e.gnt);
                end
                checks++;
                if (enable !== e.en) begin
                    failures++;
                    $display("FAIL enable t=%0t got=%h exp=%h", $time, enable, e.en);
                end
                checks++;
                if (load_data !== e.ld) begin
                    failures++;
                    $display("FAIL load_data t=%0t got=%h exp=%h", $time, load_data, e.ld);
                end
                checks++;
                if (init_done !== e.done) begin
                    failures++;
                    $display("FAIL init_done t=%0t got=%b exp=%b", $time, init_done, e.done);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;

        // Reset, then init walk with all requesters asserted, then held 111 arbitration.
        req = 3'b111;
        set_txn(0, 4'd1, 32'h11);
        set_txn(1, 4'd2, 32'h22);
        set_txn(2, 4'd9, 32'h33);
        repeat (3) tick();
        reset = 1'b0;
        repeat (24) tick();

        // Single requester: grant, then masked cycle.
        req = '0;
        repeat (3) tick();
        set_txn(0, 4'd5, 32'd7);
        req = 3'b001;
        repeat (2) tick();
        req = '0;
        repeat (3) tick();

        // Two requesters colliding on one register.
        set_txn(0, 4'd3, 32'd24974);
        set_txn(1, 4'd3, 32'd8196);
        req = 3'b011;
        tick();
        if (m_gnt_now == 0) req = 3'b010;
        else if (m_gnt_now == 1) req = 3'b001;
        tick();
        req = '0;
        repeat (3) tick();

        // Reset pulse while grants are flowing.
        req = 3'b111;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (20) tick();

        // Randomized requesters: a winner presents a fresh transaction,
        // others occasionally withdraw, and reset fires rarely.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (m_gnt_now == i) begin
                    set_txn(i, ADDR_W'($urandom_range(0, NUM_REGS-1)), $urandom);
                    req[i] = ($urandom_range(0, 1) == 1);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        set_txn(i, ADDR_W'($urandom_range(0, NUM_REGS-1)), $urandom);
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    req[i] = 1'b0;
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        req   = '0;

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_write_arbiter.md
REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of write requesters sharing the register bank write port (2..8).
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 Parameter NUM_REGS, default 16, registers in bank; ADDR_W = clog2(NUM_REGS) = 4.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester write request, bit i = requester i.
REQ-007 req_addr  input  NUM_REQ*ADDR_W  packed target register index, slice i for requester i.
REQ-008 req_data  input  NUM_REQ*DATA_W  packed write data, slice i for requester i.
REQ-009 gnt  output  NUM_REQ  registered one-hot grant, one-cycle pulse.
REQ-010 enable  output  NUM_REGS  registered one-hot register load enable, drives bank enable.
REQ-011 load_data  output  DATA_W  registered write data, drives bank load_data.
REQ-012 init_done  output  1  high once the bank clear sequence has completed.

Function
REQ-013 FSM states SHALL be INIT and RUN only; INIT entered on reset, RUN entered after the last clear write.
REQ-014 In INIT, clear counter c runs 0..NUM_REGS-1, one per cycle: enable = 1<<c, load_data = 0, gnt = 0.
REQ-015 When c = NUM_REGS-1 is issued, next cycle SHALL be RUN with init_done = 1; counter holds.
REQ-016 In INIT, req SHALL be ignored (no grant, no latching); requesters keep req asserted.
REQ-017 In RUN, at each edge, eligible = req with the requester granted at the previous edge masked off.
REQ-018 If eligible is nonzero, exactly one winner w SHALL be chosen per REQ-029; at that edge gnt <= 1<<w, enable <= 1<<req_addr[w], load_data <= req_data[w].
REQ-019 If eligible is zero, gnt <= 0 and enable <= 0; load_data SHALL hold its last value.
REQ-020 Latency: req sampled at edge E produces gnt and enable both valid in cycle after E (one cycle); at most one register written per cycle.
REQ-021 Requester i SHALL treat gnt[i] high as consumption of its request; req may stay high to present a new transaction, eligible again from the edge after the gnt cycle.
REQ-022 Same-address requests from several requesters in one cycle SHALL be serialized in arbitration order; the last granted write wins in the bank.
REQ-023 Requests deasserted before grant SHALL be dropped without any output effect.

Reset
REQ-024 reset high at edge SHALL force: state INIT, c = 0, gnt = 0, enable = 0, load_data = 0, init_done = 0, priority pointer = NUM_REQ-1 (requester 0 highest next).
REQ-025 Reset asserted mid-INIT or mid-RUN SHALL abort immediately; a pending grant is lost and the clear sequence restarts from c = 0 after release.
REQ-026 First clear write (enable = 1) SHALL appear in the first cycle after the edge where reset is sampled low.

Configuration
REQ-027 Macro REGBANK_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-028 Defined: rotating priority; search starts at (last winner + 1) mod NUM_REQ; pointer updates only on a grant.
REQ-029 Not defined: fixed priority, lowest index eligible wins; pointer logic absent; REQ-017 mask still applies.

Structure
REQ-030 Package regbank_pkg SHALL hold NUM_REGS, DATA_W, ADDR_W constants and the INIT/RUN state typedef.
REQ-031 Winner selection SHALL be a sub-module regbank_arb_pick (eligible vector + pointer in, one-hot winner out, combinational).

Verification
REQ-032 Reset release, req = 3'b111 held: enable walks 0x0001..0x8000 over 16 cycles, gnt = 0, load_data = 0, init_done rises cycle 17.
REQ-033 RUN, req0 only, addr 5, data 7: next cycle gnt = 001, enable = 0x0020, load_data = 7; following cycle gnt = 0 (mask).
REQ-034 RUN, req = 111 held, distinct addrs, RR on: grants 001,010,100,001,...; RR off: grants 001,010,001,010 (req2 starved).
REQ-035 RUN, req0 and req1 both addr 3, data 24974 and 8196: two consecutive single writes to enable 0x0008, last load_data = 8196 (RR, from reset pointer).
REQ-036 Reset pulsed one cycle while gnt active: next cycle outputs all zero, init_done = 0, clear sequence restarts at enable = 0x0001.
